// File: rtl/div_iter.sv
// Iterative restoring radix-2 divider for MIPS32 DIV/DIVU. It skips the dividend's
// leading zeros (count supplied by the LZC unit), so latency is N+1 cycles with N = 32 - lz.
module div_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic [5:0]  lz_in,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [5:0]  cnt;
  logic [5:0]  lz_clamp;
  logic [5:0]  n_start;
  logic        accept;

  logic [31:0] dvd_mag;
  logic [31:0] dsr_mag;

  // Iteration state; reloaded on every accepted start, so none of it needs reset.
  logic [31:0] dvd_sh;
  logic [31:0] dsr;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvd_raw;
  logic        neg_q;
  logic        neg_r;
  logic        dz;

  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] diff;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    r = neg ? (~v + 32'd1) : v;
    return r;
  endfunction

  function automatic logic signed [31:0] as_signed(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return s;
  endfunction

  assign lz_clamp = (lz_in > 6'd32) ? 6'd32 : lz_in;
  assign n_start  = 6'd32 - lz_clamp;
  assign accept   = (state == IDLE) && start && !cancel;

  // Operand magnitudes; only signed operations ever take an absolute value.
  assign dvd_mag = cond_neg(dividend, sign && (as_signed(dividend) < 0));
  assign dsr_mag = cond_neg(divisor,  sign && (as_signed(divisor)  < 0));

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (cancel) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = ((n_start != 6'd0) && (divisor != 32'd0)) ? ITER : FIX;
          end
        end
        ITER: begin
          if (cnt == 6'd1) begin
            state_nxt = FIX;
          end
        end
        FIX:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 6'd0;
    end else if (accept) begin
      cnt <= n_start;
    end else if (state == ITER) begin
      cnt <= cnt - 6'd1;
    end
  end

  // Restoring step: shift in the next dividend bit, keep the difference when it fits.
  assign rem_sh = {rem, dvd_sh[31]};
  assign ge     = (rem_sh >= {1'b0, dsr});
  assign diff   = rem_sh[31:0] - dsr;

  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_sh  <= dvd_mag << lz_clamp;
      dsr     <= dsr_mag;
      rem     <= 32'd0;
      quo     <= 32'd0;
      dvd_raw <= dividend;
      neg_q   <= sign && (dividend[31] ^ divisor[31]);
      neg_r   <= sign && dividend[31];
      dz      <= (divisor == 32'd0);
    end else if (state == ITER) begin
      dvd_sh  <= {dvd_sh[30:0], 1'b0};
      rem     <= ge ? diff : rem_sh[31:0];
      quo     <= {quo[30:0], ge};
    end
  end

  // Result stage: outputs only move on the edge that raises done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == FIX) && !cancel) begin
        done        <= 1'b1;
        div_by_zero <= dz;
        if (dz) begin
          quotient  <= 32'hFFFF_FFFF;
          remainder <= dvd_raw;
        end else begin
          quotient  <= cond_neg(quo, neg_q);
          remainder <= cond_neg(rem, neg_r);
        end
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: latency, signed/unsigned results,
// divide-by-zero, cancel, back-to-back issue and asynchronous reset.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [5:0]  lz_in;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  div_iter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sign        (sign),
    .dividend    (dividend),
    .divisor     (divisor),
    .lz_in       (lz_in),
    .cancel      (cancel),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Issues one operation from idle (caller sits 1 time unit after an edge) and
  // returns the number of edges from accept until done was seen, or -1 on timeout.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] lz, output int lat);
    sign = s; dividend = a; divisor = b; lz_in = lz; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; sign = 1'b0;
    dividend = 32'd0; divisor = 32'd0; lz_in = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL reset_quotient: got %h expected 0", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL reset_remainder: got %h expected 0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_divu();
    int lat;
    run_op(1'b0, 32'd100, 32'd7, 6'd25, lat);
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL divu_latency: got %0d expected 8", lat); end
    n_checks++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL divu_q: got %h expected 0000000e", quotient); end
    n_checks++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL divu_r: got %h expected 00000002", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL divu_dbz: got %b expected 0", div_by_zero); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL divu_busy_in_done: got %b expected 0", busy); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL divu_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_div_signed();
    int lat;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 6'd29, lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL sdiv_latency: got %0d expected 4", lat); end
    n_checks++; if (quotient !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sdiv_q: got %h expected fffffffd", quotient); end
    n_checks++; if (remainder !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sdiv_r: got %h expected ffffffff", remainder); end
    @(posedge clk); #1;
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 6'd29, lat);
    n_checks++; if (quotient !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sdiv_pos_neg_q: got %h expected fffffffd", quotient); end
    n_checks++; if (remainder !== 32'd1) begin n_fail++; $display("FAIL sdiv_pos_neg_r: got %h expected 00000001", remainder); end
    @(posedge clk); #1;
    run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 6'd29, lat);
    n_checks++; if (quotient !== 32'd3) begin n_fail++; $display("FAIL sdiv_neg_neg_q: got %h expected 00000003", quotient); end
    n_checks++; if (remainder !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sdiv_neg_neg_r: got %h expected ffffffff", remainder); end
    @(posedge clk); #1;
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 6'd0, lat);
    n_checks++; if (quotient !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL divu_big_q: got %h expected 7ffffffc", quotient); end
    n_checks++; if (remainder !== 32'd1) begin n_fail++; $display("FAIL divu_big_r: got %h expected 00000001", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int lat;
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd0, lat);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL ovf_latency: got %0d expected 33", lat); end
    n_checks++; if (quotient !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_q: got %h expected 80000000", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL ovf_r: got %h expected 00000000", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL ovf_dbz: got %b expected 0", div_by_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(1'b0, 32'h1234_5678, 32'd0, 6'd3, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL dz_latency: got %0d expected 1", lat); end
    n_checks++; if (quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_q: got %h expected ffffffff", quotient); end
    n_checks++; if (remainder !== 32'h1234_5678) begin n_fail++; $display("FAIL dz_r: got %h expected 12345678", remainder); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
    @(posedge clk); #1;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd0, 6'd29, lat);
    n_checks++; if (remainder !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL dz_signed_r: got %h expected fffffff9", remainder); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_signed_flag: got %b expected 1", div_by_zero); end
    @(posedge clk); #1;
    run_op(1'b0, 32'd0, 32'd5, 6'd32, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL zero_dvd_latency: got %0d expected 1", lat); end
    n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL zero_dvd_q: got %h expected 00000000", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL zero_dvd_r: got %h expected 00000000", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL zero_dvd_dbz: got %b expected 0", div_by_zero); end
    @(posedge clk); #1;
    run_op(1'b0, 32'd0, 32'd5, 6'd45, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL lz_clamp_latency: got %0d expected 1", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_cancel();
    int lat;
    logic seen;
    run_op(1'b0, 32'd100, 32'd7, 6'd25, lat);
    @(posedge clk); #1;
    sign = 1'b0; dividend = 32'hFFFF_FFFF; divisor = 32'd3; lz_in = 6'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cancel_busy_before: got %b expected 1", busy); end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy_after: got %b expected 0", busy); end
    seen = 1'b0;
    for (int c = 0; c < 36; c++) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL cancel_no_done: got %b expected 0", seen); end
    n_checks++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL cancel_q_hold: got %h expected 0000000e", quotient); end
    n_checks++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL cancel_r_hold: got %h expected 00000002", remainder); end
    run_op(1'b0, 32'hFFFF_FFFF, 32'd3, 6'd0, lat);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL after_cancel_latency: got %0d expected 33", lat); end
    n_checks++; if (quotient !== 32'h5555_5555) begin n_fail++; $display("FAIL after_cancel_q: got %h expected 55555555", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL after_cancel_r: got %h expected 00000000", remainder); end
    @(posedge clk); #1;
    sign = 1'b0; dividend = 32'd100; divisor = 32'd7; lz_in = 6'd25; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_cancel_busy: got %b expected 0", busy); end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL start_cancel_no_done: got %b expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(1'b0, 32'd100, 32'd7, 6'd25, lat);
    n_checks++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL b2b_first_q: got %h expected 0000000e", quotient); end
    sign = 1'b0; dividend = 32'd1000; divisor = 32'd10; lz_in = 6'd22; start = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy: got %b expected 1", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_accept_done: got %b expected 0", done); end
    dividend = 32'hDEAD_BEEF; divisor = 32'd1; lz_in = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int c = 4; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 11", lat); end
    n_checks++; if (quotient !== 32'd100) begin n_fail++; $display("FAIL b2b_q: got %h expected 00000064", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL b2b_r: got %h expected 00000000", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int lat;
    logic seen;
    sign = 1'b0; dividend = 32'hFFFF_FFFF; divisor = 32'd3; lz_in = 6'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b expected 0", busy); end
    n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL areset_q: got %h expected 00000000", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL areset_r: got %h expected 00000000", remainder); end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    seen = 1'b0;
    for (int c = 0; c < 36; c++) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL areset_no_done: got %b expected 0", seen); end
    run_op(1'b0, 32'd100, 32'd7, 6'd25, lat);
    n_checks++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL areset_recover_q: got %h expected 0000000e", quotient); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_overflow();
    test_div_zero();
    test_cancel();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
